bs_gnrtr_rr: RTL and testbench
==============================

Name: bs_gnrtr_rr

Overview:
Parametrised bus-system generator that links DRVRS driver FIFOs through a shared single-packet bus.
- Arbitrates pending drivers round-robin and pops one packet.
- Decodes the target field and pushes to the addressed driver, or to all drivers except the source on broadcast.
- Honours per-destination full backpressure.
- Drops packets with invalid targets and counts them.
- Sits between the driver FIFO array and the bus fabric; successor of bs_gnrtr with backpressure, invalid-target handling and wider addressing.

Parameters:
DRVRS, 4, number of driver ports (2..255).
PCKG_SZ, 128, packet width in bits.
ADDR_SZ, 8, width of target and source fields.
BROADCAST, {ADDR_SZ{1'b1}}, target value meaning "all drivers except source".

Ports:
clk  in  1  single clock, all logic on posedge.
reset  in  1  asynchronous, active-low reset.
pndng  in  DRVRS  driver FIFO non-empty, per driver; D_pop valid whenever pndng high (first-word fall-through).
full  in  DRVRS  driver FIFO full, per driver.
D_pop  in  DRVRS x PCKG_SZ  head packet of each driver FIFO.
pop  out  DRVRS  one-cycle pop strobe, one-hot or zero.
push  out  DRVRS  one-cycle push strobe, destination mask.
D_push  out  DRVRS x PCKG_SZ  packet on every lane (same value on all lanes).
drop  out  1  one-cycle pulse when a packet is discarded.
drop_cnt  out  16  saturating count of discarded packets.

Behaviour:
- Packet fields: target = [PCKG_SZ-1 -: ADDR_SZ]; source = [PCKG_SZ-1-ADDR_SZ -: ADDR_SZ]; the remainder is payload and passes untouched.
- Reset (reset=0, async):
  - State = IDLE, rr_ptr = 0.
  - pop, push, drop, drop_cnt, D_push all 0; latched packet cleared.
  - Any packet in flight is lost. Outputs are 0 within the same cycle reset asserts.
- All outputs are registered.
- FSM states: IDLE, POP, DECODE, WAIT, PUSH.
- IDLE:
  - If |pndng: winner = first set bit of pndng searching from rr_ptr upward, wrapping modulo DRVRS.
  - Register grant = winner, go to POP. Otherwise stay in IDLE.
- POP:
  - pop[grant]=1 for exactly this cycle.
  - Latch pkt = D_pop[grant] at end of cycle.
  - rr_ptr <= (grant+1) mod DRVRS.
- DECODE:
  - If target == BROADCAST: dest = all ones with bit grant cleared.
  - Else if target < DRVRS: dest = one-hot(target). Self-target is allowed.
  - Otherwise invalid: drop=1 next cycle, drop_cnt += 1 (saturates at 16'hFFFF), go to IDLE.
  - Valid: go to WAIT.
- WAIT:
  - If (dest & full) == 0, go to PUSH; otherwise stay in WAIT indefinitely (no timeout).
  - full is sampled every cycle.
- PUSH:
  - push = dest for one cycle; D_push[k] = pkt for all k; go to IDLE.
  - D_push holds pkt until the next PUSH.
- Timing: earliest latency is pndng seen at edge 0, pop high in cycle 1, push high in cycle 3. Minimum 4 cycles per packet.
- Simultaneous events:
  - pndng changes outside IDLE are ignored until the return to IDLE.
  - full rising in the same cycle push asserts is not re-checked (FIFO must absorb one entry after full).
  - DRVRS=2 broadcast reaches exactly one peer.
- pop never asserts on a driver whose pndng was low at grant time.
- push and pop are never high in the same cycle.

Decomposition:
- Package bs_pkg: state enum (IDLE, POP, DECODE, WAIT, PUSH); field-extract functions get_target and get_source parametrised by PCKG_SZ/ADDR_SZ; default BROADCAST constant.
- Sub-module bs_rr_arb: combinational round-robin priority select (inputs req, ptr; outputs winner index, valid). Instantiated once.

Test Plan:
All scenarios use DRVRS=4, PCKG_SZ=128.
1. Reset: hold reset=0 with pndng=4'hF → pop=push=0, drop_cnt=0. Release with pndng=0 → outputs stay 0 for 20 cycles.
2. Unicast: pndng=4'b0001, D_pop[0] target=2, src=0, ID=16'h0005 → pop=4'b0001 one cycle; two cycles later push=4'b0100 with D_push[2]=packet.
3. Fairness: pndng=4'hF held, each driver targeting (i+1)%4 → pop order 0,1,2,3,0,1 at 4-cycle spacing; push masks 2,4,8,1.
4. Broadcast: only driver 1 pending, target=8'hFF → push=4'b1101; push[1]=0.
5. Backpressure: target=3, full[3]=1 for 10 cycles after pop → push stays 0 throughout. push=4'b1000 the cycle after WAIT sees full[3]=0.
6. Invalid target and reset: target=8'h07 → pop pulse, drop pulse, drop_cnt=1, no push. Next packet: reset=0 asserted while in WAIT → pop, push and drop_cnt are 0 immediately and the FSM is in IDLE.

Source files
------------

// File: rtl/bs_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : bs_pkg
// Brief   : Shared types, constants and packet field helpers for bs_gnrtr_rr.
// Revision: 1.0 - initial release
// ============================================================================
package bs_pkg;

    localparam int c_MAX_PCKG = 1024;
    localparam int c_MAX_ADDR = 32;
    localparam logic [c_MAX_ADDR-1:0] c_BROADCAST_ALL = '1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        DECODE = 3'd2,
        WAIT   = 3'd3,
        PUSH   = 3'd4
    } state_t;

    // Packets are zero-extended to c_MAX_PCKG; the result is masked to addr_sz bits.
    function automatic logic [c_MAX_ADDR-1:0] get_target(input logic [c_MAX_PCKG-1:0] pkt,
                                                         input int pckg_sz,
                                                         input int addr_sz);
        return c_MAX_ADDR'(pkt >> (pckg_sz - addr_sz)) & ~(c_BROADCAST_ALL << addr_sz);
    endfunction

    function automatic logic [c_MAX_ADDR-1:0] get_source(input logic [c_MAX_PCKG-1:0] pkt,
                                                         input int pckg_sz,
                                                         input int addr_sz);
        return c_MAX_ADDR'(pkt >> (pckg_sz - 2 * addr_sz)) & ~(c_BROADCAST_ALL << addr_sz);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bs_rr_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : bs_rr_arb
// Brief   : Combinational round-robin select: first request at or above ptr.
// Revision: 1.0 - initial release
// ============================================================================
module bs_rr_arb #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    logic [N-1:0]     w_rot;
    logic [IDX_W-1:0] w_off;
    logic [IDX_W:0]   w_sum;

    // Rotate requests so ptr lands on bit 0, then pick the lowest set bit.
    always_comb begin
        w_rot = N'({req, req} >> ptr);
        w_off = '0;
        valid = 1'b0;
        for (int j = N - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = IDX_W'(j);
                valid = 1'b1;
            end
        end
        w_sum = {1'b0, ptr} + {1'b0, w_off};
        if (w_sum >= (IDX_W + 1)'(N)) begin
            w_sum = w_sum - (IDX_W + 1)'(N);
        end
        winner = w_sum[IDX_W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/bs_gnrtr_rr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : bs_gnrtr_rr
// Brief   : Round-robin single-packet bus between driver FIFOs with backpressure.
// Revision: 1.0 - initial release
// ============================================================================
module bs_gnrtr_rr
    import bs_pkg::*;
#(
    parameter int                 DRVRS     = 4,
    parameter int                 PCKG_SZ   = 128,
    parameter int                 ADDR_SZ   = 8,
    parameter logic [ADDR_SZ-1:0] BROADCAST = c_BROADCAST_ALL[ADDR_SZ-1:0]
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DRVRS-1:0]           pndng,
    input  logic [DRVRS-1:0]           full,
    input  logic [DRVRS*PCKG_SZ-1:0]   D_pop,
    output logic [DRVRS-1:0]           pop,
    output logic [DRVRS-1:0]           push,
    output logic [DRVRS*PCKG_SZ-1:0]   D_push,
    output logic                       drop,
    output logic [15:0]                drop_cnt
);

    localparam int               c_IDX_W = $clog2(DRVRS);
    localparam logic [DRVRS-1:0] c_ONE   = DRVRS'(1);

    state_t               r_state;
    logic [c_IDX_W-1:0]   r_grant;
    logic [c_IDX_W-1:0]   r_ptr;
    logic [PCKG_SZ-1:0]   r_pkt;
    logic [PCKG_SZ-1:0]   r_dpush;
    logic [DRVRS-1:0]     r_pop;
    logic [DRVRS-1:0]     r_push;
    logic [DRVRS-1:0]     r_dest;
    logic                 r_drop;
    logic [15:0]          r_drop_cnt;

    logic [c_IDX_W-1:0]   w_winner;
    logic                 w_valid;
    logic [PCKG_SZ-1:0]   w_sel;
    logic [ADDR_SZ-1:0]   w_target;
    logic                 w_is_bcast;
    logic                 w_tgt_ok;
    logic [DRVRS-1:0]     w_dest;

    bs_rr_arb #(
        .N     (DRVRS),
        .IDX_W (c_IDX_W)
    ) u_arb (
        .req    (pndng),
        .ptr    (r_ptr),
        .winner (w_winner),
        .valid  (w_valid)
    );

    always_comb begin
        w_sel = '0;
        for (int k = 0; k < DRVRS; k++) begin
            if (r_grant == c_IDX_W'(k)) begin
                w_sel = D_pop[k*PCKG_SZ +: PCKG_SZ];
            end
        end
    end

    // Destination decode from the latched packet; broadcast excludes the source lane.
    always_comb begin
        w_target   = ADDR_SZ'(get_target(c_MAX_PCKG'(r_pkt), PCKG_SZ, ADDR_SZ));
        w_is_bcast = (w_target == BROADCAST);
        w_tgt_ok   = w_is_bcast || (c_MAX_ADDR'(w_target) < c_MAX_ADDR'(DRVRS));
        w_dest     = w_is_bcast ? ~(c_ONE << r_grant) : (c_ONE << w_target);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_ptr      <= '0;
            r_pkt      <= '0;
            r_dpush    <= '0;
            r_pop      <= '0;
            r_push     <= '0;
            r_dest     <= '0;
            r_drop     <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_pop  <= '0;
            r_push <= '0;
            r_drop <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_grant <= w_winner;
                        r_pop   <= c_ONE << w_winner;
                        r_state <= POP;
                    end
                end
                POP: begin
                    r_pkt   <= w_sel;
                    r_ptr   <= (r_grant == c_IDX_W'(DRVRS - 1)) ? '0 : r_grant + c_IDX_W'(1);
                    r_state <= DECODE;
                end
                DECODE: begin
                    if (!w_tgt_ok) begin
                        r_drop <= 1'b1;
                        if (r_drop_cnt != 16'hFFFF) begin
                            r_drop_cnt <= r_drop_cnt + 16'd1;
                        end
                        r_state <= IDLE;
                    end else begin
                        r_dest <= w_dest;
                        // Skip WAIT when nothing is blocked so the push lands one cycle sooner.
                        if ((w_dest & full) == '0) begin
                            r_push  <= w_dest;
                            r_dpush <= r_pkt;
                            r_state <= PUSH;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if ((r_dest & full) == '0) begin
                        r_push  <= r_dest;
                        r_dpush <= r_pkt;
                        r_state <= PUSH;
                    end
                end
                PUSH: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign pop      = r_pop;
    assign push     = r_push;
    assign D_push   = {DRVRS{r_dpush}};
    assign drop     = r_drop;
    assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bs_gnrtr_rr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_bs_gnrtr_rr
// Brief   : Self-checking bench for bs_gnrtr_rr with FIFO model and scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bs_gnrtr_rr;

    localparam int c_DRVRS = 4;
    localparam int c_PW    = 128;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [c_DRVRS-1:0]      pndng;
    logic [c_DRVRS-1:0]      full;
    logic [c_DRVRS*c_PW-1:0] D_pop;
    logic [c_DRVRS-1:0]      pop;
    logic [c_DRVRS-1:0]      push;
    logic [c_DRVRS*c_PW-1:0] D_push;
    logic                    drop;
    logic [15:0]             drop_cnt;

    always #5 clk = ~clk;

    bs_gnrtr_rr #(
        .DRVRS   (c_DRVRS),
        .PCKG_SZ (c_PW),
        .ADDR_SZ (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .full     (full),
        .D_pop    (D_pop),
        .pop      (pop),
        .push     (push),
        .D_push   (D_push),
        .drop     (drop),
        .drop_cnt (drop_cnt)
    );

    typedef struct {
        logic [3:0]      mask;
        logic [c_PW-1:0] pkt;
    } push_t;

    typedef struct {
        int         drv;
        logic [7:0] tgt;
        logic [3:0] exp_push;
        logic       exp_drop;
    } vec_t;

    int              checks = 0;
    int              errors = 0;
    logic [c_PW-1:0] drv_q [c_DRVRS][$];
    logic [3:0]      exp_pop_q[$];
    push_t           exp_push_q[$];
    int              n_pop = 0;
    int              n_drop = 0;
    int              cyc = 0;
    int              last_pop_cyc = 0;
    int              last_push_cyc = 0;
    int              pop_gap = 0;
    logic            gap_armed = 1'b0;
    logic            gap_first = 1'b0;
    int              exp_dc = 0;
    logic [3:0]      model_ps;

    task automatic chk(input string name, input logic [c_PW-1:0] act, input logic [c_PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Driver FIFO model: head removed just after the edge that ends a pop cycle.
    initial begin
        pndng = '0;
        D_pop = '0;
        forever begin
            @(negedge clk);
            model_ps = pop;
            @(posedge clk);
            #1;
            for (int k = 0; k < c_DRVRS; k++) begin
                if (reset && model_ps[k] && drv_q[k].size() > 0) begin
                    void'(drv_q[k].pop_front());
                end
                pndng[k] = (drv_q[k].size() > 0);
                D_pop[k*c_PW +: c_PW] = (drv_q[k].size() > 0) ? drv_q[k][0] : '0;
            end
        end
    end

    // Output monitor against the scoreboard.
    always @(negedge clk) begin
        push_t e;
        cyc++;
        if (reset) begin
            if (pop != '0) begin
                n_pop++;
                pop_gap = cyc - last_pop_cyc;
                last_pop_cyc = cyc;
                if (exp_pop_q.size() == 0) begin
                    chk("unexpected_pop", c_PW'(pop), '0);
                end else begin
                    chk("pop_mask", c_PW'(pop), c_PW'(exp_pop_q.pop_front()));
                end
                if (gap_armed) begin
                    if (gap_first) gap_first = 1'b0;
                    else chk("pop_spacing", c_PW'(pop_gap), c_PW'(4));
                end
            end
            if (push != '0) begin
                last_push_cyc = cyc;
                if (exp_push_q.size() == 0) begin
                    chk("unexpected_push", c_PW'(push), '0);
                end else begin
                    e = exp_push_q.pop_front();
                    chk("push_mask", c_PW'(push), c_PW'(e.mask));
                    for (int k = 0; k < c_DRVRS; k++) begin
                        chk("d_push_lane", D_push[k*c_PW +: c_PW], e.pkt);
                    end
                end
                if (pop != '0) chk("push_pop_overlap", c_PW'(pop), '0);
            end
            if (drop) n_drop++;
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    function automatic logic [c_PW-1:0] mk(input logic [7:0] t, input logic [7:0] s, input logic [15:0] id);
        return {t, s, $urandom(), $urandom(), $urandom(), id};
    endfunction

    task automatic send(input int drv, input logic [7:0] tgt, input logic [15:0] id, input logic [3:0] exp_mask);
        push_t e;
        e.pkt  = mk(tgt, 8'(drv), id);
        e.mask = exp_mask;
        drv_q[drv].push_back(e.pkt);
        exp_pop_q.push_back(4'b0001 << drv);
        if (exp_mask != 4'b0000) exp_push_q.push_back(e);
    endtask

    task automatic flush;
        for (int k = 0; k < c_DRVRS; k++) drv_q[k].delete();
        exp_pop_q.delete();
        exp_push_q.delete();
    endtask

    task automatic do_reset;
        reset = 1'b0;
        full  = '0;
        flush();
        exp_dc = 0;
        repeat (3) tick();
        reset = 1'b1;
    endtask

    task automatic wait_pop(output int cycles);
        int start;
        start  = n_pop;
        cycles = 0;
        while (n_pop == start && cycles < 50) begin
            tick();
            cycles++;
        end
        if (n_pop == start) chk("pop_timeout", c_PW'(cycles), '0);
    endtask

    task automatic drain;
        int n;
        n = 0;
        while ((exp_pop_q.size() != 0 || exp_push_q.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        if (exp_pop_q.size() != 0 || exp_push_q.size() != 0) chk("drain_timeout", c_PW'(n), '0);
        repeat (3) tick();
    endtask

    vec_t vt[9];

    initial begin
        int cyc_n;
        int d0;
        vt[0] = '{0, 8'h02, 4'b0100, 1'b0};
        vt[1] = '{1, 8'hFF, 4'b1101, 1'b0};
        vt[2] = '{3, 8'h03, 4'b1000, 1'b0};
        vt[3] = '{2, 8'h00, 4'b0001, 1'b0};
        vt[4] = '{0, 8'hFF, 4'b1110, 1'b0};
        vt[5] = '{3, 8'h07, 4'b0000, 1'b1};
        vt[6] = '{2, 8'h04, 4'b0000, 1'b1};
        vt[7] = '{1, 8'h03, 4'b1000, 1'b0};
        vt[8] = '{3, 8'hFE, 4'b0000, 1'b1};

        // Reset held with all drivers pending.
        reset = 1'b0;
        full  = '0;
        for (int k = 0; k < c_DRVRS; k++) drv_q[k].push_back(mk(8'h01, 8'(k), 16'hDEAD));
        repeat (3) tick();
        chk("rst_pop", c_PW'(pop), '0);
        chk("rst_push", c_PW'(push), '0);
        chk("rst_drop", c_PW'(drop), '0);
        chk("rst_drop_cnt", c_PW'(drop_cnt), '0);
        chk("rst_d_push", D_push[c_PW-1:0], '0);
        flush();
        repeat (2) tick();
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_outputs", c_PW'({pop, push, drop}), '0);
        end

        // Single-driver transactions from the vector table.
        for (int i = 0; i < 9; i++) begin
            d0 = n_drop;
            send(vt[i].drv, vt[i].tgt, 16'(i + 5), vt[i].exp_push);
            wait_pop(cyc_n);
            drain();
            if (vt[i].exp_drop) exp_dc++;
            chk("drop_pulses", c_PW'(n_drop - d0), c_PW'(vt[i].exp_drop));
            chk("drop_cnt", c_PW'(drop_cnt), c_PW'(exp_dc));
            if (!vt[i].exp_drop) chk("pop_to_push", c_PW'(last_push_cyc - last_pop_cyc), c_PW'(2));
        end

        // Fairness: all pending, round-robin from pointer 0.
        do_reset();
        send(0, 8'h01, 16'h0100, 4'b0010);
        send(1, 8'h02, 16'h0101, 4'b0100);
        send(2, 8'h03, 16'h0102, 4'b1000);
        send(3, 8'h00, 16'h0103, 4'b0001);
        send(0, 8'h01, 16'h0104, 4'b0010);
        send(1, 8'h02, 16'h0105, 4'b0100);
        gap_armed = 1'b1;
        gap_first = 1'b1;
        drain();
        gap_armed = 1'b0;

        // Backpressure: destination full for 10 cycles after the pop.
        full = 4'b1000;
        send(0, 8'h03, 16'h0200, 4'b1000);
        wait_pop(cyc_n);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold", c_PW'(push), '0);
        end
        full = 4'b0000;
        tick();
        chk("bp_release", c_PW'(push), c_PW'(4'b1000));
        drain();

        // Invalid target: single drop pulse two cycles after the pop.
        send(2, 8'h07, 16'h0300, 4'b0000);
        wait_pop(cyc_n);
        tick();
        chk("inv_drop_early", c_PW'(drop), '0);
        tick();
        chk("inv_drop", c_PW'(drop), c_PW'(1));
        chk("inv_drop_cnt", c_PW'(drop_cnt), c_PW'(1));
        tick();
        chk("inv_drop_end", c_PW'(drop), '0);
        chk("inv_no_push", c_PW'(push), '0);

        // Reset asserted mid-cycle while waiting on a full destination.
        full = 4'b1000;
        send(1, 8'h03, 16'h0400, 4'b1000);
        wait_pop(cyc_n);
        repeat (3) tick();
        #1 reset = 1'b0;
        #1;
        chk("arst_pop", c_PW'(pop), '0);
        chk("arst_push", c_PW'(push), '0);
        chk("arst_drop_cnt", c_PW'(drop_cnt), '0);
        chk("arst_d_push", D_push[c_PW-1:0], '0);
        flush();
        full = '0;
        repeat (2) tick();
        reset = 1'b1;

        // Back in IDLE with pointer 0: driver 1 must beat driver 3, pop two cycles after enqueue.
        send(1, 8'h00, 16'h0500, 4'b0001);
        send(3, 8'h02, 16'h0501, 4'b0100);
        wait_pop(cyc_n);
        chk("post_rst_latency", c_PW'(cyc_n), c_PW'(2));
        drain();
        chk("post_rst_drop_cnt", c_PW'(drop_cnt), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
